// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// ysyx_22041071_axi_rd_arb_pkg: shared encodings for the two-master AXI read arbiter.
// Rev 1.0
`default_nettype none

package ysyx_22041071_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] SIZE_1B = 2'b00;
  localparam logic [1:0] SIZE_2B = 2'b01;
  localparam logic [1:0] SIZE_4B = 2'b10;
  localparam logic [1:0] SIZE_8B = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ysyx_22041071_rr_arb2.sv
// ysyx_22041071_rr_arb2: 2-input round-robin picker; on a tie the input that did not win last time is granted.
// Rev 1.0
`default_nettype none

module ysyx_22041071_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ysyx_22041071_axi_rd_arb: shares one AXI read engine between IFU (m0) and LSU (m1).
// Optional watchdog: YSYX_22041071_AXI_RD_ARB_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int LEN_W       = 8,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_ar_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [1:0]        m0_size,
  output logic              m0_ar_ready,
  output logic              m0_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  input  logic              m0_r_ready,
  input  logic              m1_ar_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [1:0]        m1_size,
  output logic              m1_ar_ready,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  input  logic              m1_r_ready,
  output logic              s_ar_valid,
  output logic [ID_W-1:0]   s_id,
  output logic [ADDR_W-1:0] s_addr,
  output logic [LEN_W-1:0]  s_len,
  output logic [1:0]        s_size,
  input  logic              s_ar_ready,
  input  logic              s_r_valid,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_last,
  output logic              s_r_ready,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              owner;
  logic              last_grant;
  logic [1:0]        gnt;
  logic              own_r_ready;
  logic              to_fire;
  logic              idle_drain;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic [1:0]        beat_resp;
  logic              beat_last;

  ysyx_22041071_rr_arb2 u_rr_arb2 (
    .req        ({m1_ar_valid, m0_ar_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign own_r_ready = owner ? m1_r_ready : m0_r_ready;
  assign s_id        = {{(ID_W-1){1'b0}}, owner};

`ifdef YSYX_22041071_AXI_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt;
  logic             r_hs;

  assign r_hs       = (state == ST_DATA) && !to_fire && s_r_valid && own_r_ready;
  assign to_fire    = (state == ST_DATA) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign idle_drain = 1'b1;

  // Held at zero outside DATA, so it starts from zero on every entry to DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state != ST_DATA || r_hs) begin
      to_cnt <= '0;
    end else if (!to_fire) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // Watchdog compiled out: DATA waits for the engine's last beat indefinitely.
  assign to_fire    = (TIMEOUT_CYC < 0);
  assign idle_drain = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      s_addr     <= '0;
      s_len      <= '0;
      s_size     <= SIZE_1B;
    end else begin
      if (state == ST_IDLE && gnt != 2'b00) begin
        owner  <= gnt[1];
        s_addr <= gnt[1] ? m1_addr : m0_addr;
        s_len  <= gnt[1] ? m1_len  : m0_len;
        s_size <= gnt[1] ? m1_size : m0_size;
      end
      if (state == ST_ADDR && s_ar_ready) begin
        last_grant <= owner;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    s_ar_valid  = 1'b0;
    s_r_ready   = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    beat_valid  = 1'b0;
    beat_data   = '0;
    beat_resp   = RESP_OKAY;
    beat_last   = 1'b0;
    busy        = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        s_r_ready = idle_drain;
        if (gnt != 2'b00) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        s_ar_valid = 1'b1;
        if (s_ar_ready) begin
          m0_ar_ready = !owner;
          m1_ar_ready = owner;
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (to_fire) begin
          // Synthetic error beat; the engine is not allowed to advance meanwhile.
          beat_valid = 1'b1;
          beat_resp  = RESP_SLVERR;
          beat_last  = 1'b1;
          if (own_r_ready) state_nxt = ST_IDLE;
        end else begin
          s_r_ready  = own_r_ready;
          beat_valid = s_r_valid;
          beat_data  = s_r_data;
          beat_resp  = s_r_resp;
          beat_last  = s_r_last;
          if (s_r_valid && own_r_ready && s_r_last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    m0_r_valid = beat_valid && !owner;
    m0_r_data  = owner ? '0 : beat_data;
    m0_r_resp  = owner ? 2'b00 : beat_resp;
    m0_r_last  = beat_last && !owner;
    m1_r_valid = beat_valid && owner;
    m1_r_data  = owner ? beat_data : '0;
    m1_r_resp  = owner ? beat_resp : 2'b00;
    m1_r_last  = beat_last && owner;
  end

endmodule

`default_nettype wire
